// File: rtl/led_frame_writer.sv
// ----------------------------------------------------------------------------
// led_frame_writer
//
// Writes a raster-order RGB pixel stream into the back half of a double-
// buffered pixel RAM. The RAM is split into a hi bank (rows 0..ROWS/2-1) and a
// lo bank (the remaining rows). When a complete frame has been written, the
// block requests a buffer swap through selected_buffer. It then stalls the
// stream until the panel reports, through actual_buffer, that it has moved to
// the new buffer. This way the buffer being displayed is never overwritten.
//
// Ports
//   clk              system clock
//   rst              asynchronous reset, active-high
//   s_valid          pixel valid
//   s_ready          writer can accept a pixel (registered)
//   s_data           pixel {blue[23:16], green[15:8], red[7:0]}
//   s_sof            marks the current pixel as the first of a frame
//   wr_addr          RAM write address {buffer, row[3:0], col[4:0]}
//   wr_data          RAM write data (s_data delayed by one cycle)
//   wr_en_hi         write strobe for the hi bank
//   wr_en_lo         write strobe for the lo bank
//   selected_buffer  buffer the panel must display from its next frame start
//   actual_buffer    buffer the panel is currently displaying
//   frame_done       one-cycle pulse when a frame has been fully written
//   sync_err         one-cycle pulse when s_sof arrives mid-frame
// ----------------------------------------------------------------------------
module led_frame_writer #(
    parameter int COLS   = 32,
    parameter int ROWS   = 32,
    parameter int DATA_W = 24
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [DATA_W-1:0]                     s_data,
    input  logic                                  s_sof,
    output logic [$clog2(COLS)+$clog2(ROWS)-1:0]  wr_addr,
    output logic [DATA_W-1:0]                     wr_data,
    output logic                                  wr_en_hi,
    output logic                                  wr_en_lo,
    output logic                                  selected_buffer,
    input  logic                                  actual_buffer,
    output logic                                  frame_done,
    output logic                                  sync_err
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = COL_W + ROW_W;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITE     = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                sel_q, sel_d;
    logic                ready_q, ready_d;
    logic                wr_en_hi_q, wr_en_hi_d;
    logic                wr_en_lo_q, wr_en_lo_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                frame_done_q, frame_done_d;
    logic                sync_err_q, sync_err_d;

    logic                accept;
    logic                last_pixel;
    logic                do_wr;
    logic [COL_W-1:0]    wr_col;
    logic [ROW_W-1:0]    wr_row;

    assign accept     = s_valid && ready_q;
    assign last_pixel = (col_q == COL_MAX) && (row_q == ROW_MAX);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        sel_d        = sel_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        do_wr        = 1'b0;
        wr_col       = col_q;
        wr_row       = row_q;

        case (state_q)
            ST_IDLE: begin
                // Pixels ahead of the first start-of-frame are dropped.
                if (accept && s_sof) begin
                    do_wr   = 1'b1;
                    wr_col  = '0;
                    wr_row  = '0;
                    col_d   = COL_W'(1);
                    row_d   = '0;
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (accept) begin
                    do_wr = 1'b1;
                    if (s_sof) begin
                        // Resynchronise: abandon the partial frame. This
                        // pixel becomes (0,0) of a new frame in the same
                        // back buffer, without a swap.
                        wr_col     = '0;
                        wr_row     = '0;
                        col_d      = COL_W'(1);
                        row_d      = '0;
                        sync_err_d = 1'b1;
                    end else if (last_pixel) begin
                        col_d        = '0;
                        row_d        = '0;
                        sel_d        = ~sel_q;
                        frame_done_d = 1'b1;
                        state_d      = ST_SWAP_WAIT;
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            ST_SWAP_WAIT: begin
                // Hold the stream until the panel has moved onto the buffer
                // that was just written.
                if (actual_buffer == sel_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d != ST_SWAP_WAIT);

        // The address targets the back buffer as it was before any toggle
        // in this same cycle. The bank is chosen by the row MSB.
        wr_en_hi_d = do_wr && !wr_row[ROW_W-1];
        wr_en_lo_d = do_wr &&  wr_row[ROW_W-1];
        wr_addr_d  = do_wr ? {~sel_q, wr_row[ROW_W-2:0], wr_col} : wr_addr_q;
        wr_data_d  = do_wr ? s_data : wr_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            sel_q        <= 1'b0;
            ready_q      <= 1'b0;
            wr_en_hi_q   <= 1'b0;
            wr_en_lo_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            sel_q        <= sel_d;
            ready_q      <= ready_d;
            wr_en_hi_q   <= wr_en_hi_d;
            wr_en_lo_q   <= wr_en_lo_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign s_ready         = ready_q;
    assign wr_en_hi        = wr_en_hi_q;
    assign wr_en_lo        = wr_en_lo_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign selected_buffer = sel_q;
    assign frame_done      = frame_done_q;
    assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_led_frame_writer.sv
module tb_led_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic [9:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_en_hi;
    logic        wr_en_lo;
    logic        selected_buffer;
    logic        actual_buffer = 1'b0;
    logic        frame_done;
    logic        sync_err;

    int total = 0;
    int bad   = 0;

    led_frame_writer dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .s_sof           (s_sof),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_en_hi        (wr_en_hi),
        .wr_en_lo        (wr_en_lo),
        .selected_buffer (selected_buffer),
        .actual_buffer   (actual_buffer),
        .frame_done      (frame_done),
        .sync_err        (sync_err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge, then return 1ns after
    // the following rising edge. acc reports whether the pixel was accepted.
    task automatic drive(input logic v, input logic sof, input logic [23:0] d, output bit acc);
        @(negedge clk);
        s_valid = v;
        s_sof   = sof;
        s_data  = d;
        acc     = (v && s_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        total++; if (wr_en_hi !== 1'b0) begin bad++; $display("FAIL rst_wr_en_hi got=%b exp=0", wr_en_hi); end
        total++; if (wr_en_lo !== 1'b0) begin bad++; $display("FAIL rst_wr_en_lo got=%b exp=0", wr_en_lo); end
        total++; if (wr_addr !== 10'h000) begin bad++; $display("FAIL rst_wr_addr got=%h exp=000", wr_addr); end
        total++; if (wr_data !== 24'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=000000", wr_data); end
        total++; if (selected_buffer !== 1'b0) begin bad++; $display("FAIL rst_selected_buffer got=%b exp=0", selected_buffer); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err got=%b exp=0", sync_err); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", s_ready); end
    endtask

    // Send a full 1024-pixel frame (sof on the first pixel) and check every
    // write against the raster model: pixel i lands at {b, i[8:0]} in bank i[9].
    task automatic test_frame(input logic b, input logic [23:0] base, input bit gaps,
                              input bit exp_sync, input string tag);
        int          i   = 0;
        int          cyc = 0;
        bit          acc;
        logic        v;
        logic [9:0]  idx;
        logic [38:0] got, exp;
        while (i < 1024 && cyc < 20000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(v, (i == 0), base + 24'(i), acc);
            cyc++;
            if (acc) begin
                idx = 10'(i);
                got = {wr_en_hi, wr_en_lo, wr_addr, wr_data, frame_done, sync_err, selected_buffer};
                exp = {~idx[9], idx[9], b, idx[8:0], base + 24'(i), (i == 1023),
                       ((i == 0) && exp_sync), ((i == 1023) ? b : ~b)};
                total++;
                if (got !== exp) begin
                    bad++;
                    if (bad < 30) $display("FAIL %s pix=%0d got={hi,lo,addr,data,fd,se,sel}=%h exp=%h", tag, i, got, exp);
                end
                i++;
            end else begin
                total++;
                if ({wr_en_hi, wr_en_lo, frame_done, sync_err} !== 4'b0000) begin
                    bad++;
                    if (bad < 30) $display("FAIL %s_idle_cycle pix=%0d got={hi,lo,fd,se}=%b exp=0000", tag, i,
                                           {wr_en_hi, wr_en_lo, frame_done, sync_err});
                end
            end
        end
        s_valid = 1'b0;
        total++; if (i != 1024) begin bad++; $display("FAIL %s_timeout accepted=%0d exp=1024", tag, i); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL %s_swap_wait_ready got=%b exp=0", tag, s_ready); end
    endtask

    // Panel takes the swap: s_ready must come back within 2 cycles.
    task automatic test_swap_release(input logic val, input string tag);
        @(negedge clk);
        s_valid       = 1'b0;
        actual_buffer = val;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            if (s_ready === 1'b1) break;
        end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b exp=1", tag, s_ready); end
        total++; if (selected_buffer !== val) begin bad++; $display("FAIL %s_sel got=%b exp=%b", tag, selected_buffer, val); end
    endtask

    task automatic test_swap_wait();
        bit acc;
        int errs = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 1'b0, 24'hDEAD00 + 24'(k), acc);
            total++;
            if ({acc, s_ready, wr_en_hi, wr_en_lo} !== 4'b0000) begin
                bad++;
                if (errs++ < 5) $display("FAIL swap_wait_stall cyc=%0d got={acc,rdy,hi,lo}=%b exp=0000", k,
                                         {acc, s_ready, wr_en_hi, wr_en_lo});
            end
        end
        test_swap_release(1'b1, "swap_wait_release");
    endtask

    task automatic test_drop_no_sof();
        bit acc;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 24'h550000 + 24'(k), acc);
            total++;
            if ({acc, wr_en_hi, wr_en_lo} !== 3'b100) begin
                bad++;
                $display("FAIL drop_no_sof pix=%0d got={acc,hi,lo}=%b exp=100", k, {acc, wr_en_hi, wr_en_lo});
            end
        end
        test_frame(1'b1, 24'h100000, 1'b0, 1'b0, "drop_frame");
        test_swap_release(1'b1, "drop_release");
    endtask

    task automatic test_sync_err();
        bit          acc;
        logic [9:0]  idx;
        logic [37:0] got, exp;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, (k == 0), 24'h300000 + 24'(k), acc);
            idx = 10'(k);
            got = {acc, wr_en_hi, wr_en_lo, wr_addr, wr_data, frame_done, sync_err};
            exp = {1'b1, 1'b1, 1'b0, 1'b0, idx[8:0], 24'h300000 + 24'(k), 1'b0, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                if (bad < 30) $display("FAIL sync_prefix pix=%0d got=%h exp=%h", k, got, exp);
            end
        end
        // The frame's first pixel carries sof mid-frame and must resync.
        test_frame(1'b0, 24'h400000, 1'b0, 1'b1, "sync_frame");
        test_swap_release(1'b0, "sync_release");
    endtask

    task automatic test_random_gaps();
        test_frame(1'b1, 24'h600000, 1'b1, 1'b0, "gaps_frame");
        test_swap_release(1'b1, "gaps_release");
    endtask

    task automatic test_reset_mid();
        bit acc;
        for (int k = 0; k < 600; k++) begin
            drive(1'b1, (k == 0), 24'h700000 + 24'(k), acc);
        end
        // Pixel 599 is row 18, col 23: lo bank, buffer 0.
        total++;
        if ({wr_en_hi, wr_en_lo, wr_addr} !== {2'b01, 10'h057}) begin
            bad++;
            $display("FAIL mid_pix599 got={hi,lo,addr}=%b_%h exp=01_057", {wr_en_hi, wr_en_lo}, wr_addr);
        end
        @(negedge clk);
        rst           = 1'b1;
        s_valid       = 1'b0;
        actual_buffer = 1'b0;
        #1;
        total++;
        if ({s_ready, wr_en_hi, wr_en_lo, wr_addr, wr_data, selected_buffer, frame_done, sync_err} !== 40'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs got={rdy,hi,lo,addr,data,sel,fd,se}=%h exp=0",
                     {s_ready, wr_en_hi, wr_en_lo, wr_addr, wr_data, selected_buffer, frame_done, sync_err});
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_frame(1'b1, 24'h800000, 1'b0, 1'b0, "post_reset_frame");
    endtask

    initial begin
        test_reset();
        test_frame(1'b1, 24'h000000, 1'b0, 1'b0, "b2b_frame");
        test_swap_wait();
        test_frame(1'b0, 24'h200000, 1'b0, 1'b0, "buf0_frame");
        test_swap_release(1'b0, "buf0_release");
        test_drop_no_sof();
        test_sync_err();
        test_random_gaps();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
